// File: rtl/norm_shift_pipe_pkg.sv
// Shared width helpers for the normalising shift pipeline.
package norm_shift_pipe_pkg;

    // Width of a leading-zero count for an n-bit fraction (never below 1 bit).
    function automatic int lzc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The adjusted exponent is one bit wider than the input; it cannot overflow
    // as long as the largest shift (n-1) fits in the input exponent's range.
    function automatic bit exp_w_ok(input int n, input int e);
        return (e >= 2) && (e <= 31) && (longint'(n) <= (longint'(1) << (e - 1)));
    endfunction

endpackage

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter; non-power-of-two widths are padded on the LSB side.
module norm_lzc
    import norm_shift_pipe_pkg::*;
#(
    parameter int C_N = 64
) (
    input  logic [C_N-1:0]          frac,
    output logic [lzc_w(C_N)-1:0]   lzc,
    output logic                    zero
);

    localparam int LW = lzc_w(C_N);
    localparam int P  = 1 << LW;

    logic [P-1:0] pad;

    // LSB-side zeros never affect the count of zeros above the leading one.
    if (P == C_N) begin : g_exact
        assign pad = frac;
    end else begin : g_pad
        assign pad = {frac, {(P - C_N){1'b0}}};
    end

    always_comb begin
        logic found;
        lzc   = '0;
        found = 1'b0;
        for (int i = P - 1; i >= 0; i--) begin
            if (!found && pad[i]) begin
                lzc   = LW'(P - 1 - i);
                found = 1'b1;
            end
        end
    end

    assign zero = ~|frac;

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage normaliser: S1 registers the beat and its leading-zero count,
// S2 registers the barrel-shifted fraction and the adjusted exponent.
module norm_shift_pipe
    import norm_shift_pipe_pkg::*;
#(
    parameter int C_N = 64,
    parameter int C_E = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_sign,
    input  logic [C_E-1:0]          s_exp,
    input  logic [C_N-1:0]          s_frac,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_sign,
    output logic [C_E:0]            m_exp,
    output logic [C_N-1:0]          m_frac,
    output logic [lzc_w(C_N)-1:0]   m_lzc,
    output logic                    m_zero
);

    localparam int LW = lzc_w(C_N);

    if (!exp_w_ok(C_N, C_E)) begin : g_bad_widths
        $fatal(1, "norm_shift_pipe: C_N must not exceed 2**(C_E-1)");
    end

    logic            v1, v2;
    logic            en1, en2;
    logic            sign1, zero1;
    logic [C_E-1:0]  exp1;
    logic [C_N-1:0]  frac1;
    logic [LW-1:0]   lzc1;

    logic [LW-1:0]   lzc0;
    logic            zero0;
    logic [C_N-1:0]  frac_sh;
    logic [C_E:0]    exp_adj;

    assign en2     = ~v2 | m_ready;
    assign en1     = ~v1 | en2;
    assign s_ready = en1 & rst_n;
    assign m_valid = v2;

    norm_lzc #(.C_N(C_N)) u_lzc (
        .frac (s_frac),
        .lzc  (lzc0),
        .zero (zero0)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            exp1  <= '0;
            frac1 <= '0;
            lzc1  <= '0;
            zero1 <= 1'b0;
        end else if (en1) begin
            v1 <= s_valid;
            if (s_valid) begin
                sign1 <= s_sign;
                exp1  <= s_exp;
                frac1 <= s_frac;
                lzc1  <= lzc0;
                zero1 <= zero0;
            end
        end
    end

    // Barrel shifter: one conditional power-of-two stage per count bit.
    always_comb begin
        frac_sh = frac1;
        for (int k = 0; k < LW; k++) begin
            if (lzc1[k]) begin
                frac_sh = frac_sh << (1 << k);
            end
        end
    end

    assign exp_adj = {exp1[C_E-1], exp1} - {{(C_E + 1 - LW){1'b0}}, lzc1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            m_sign <= 1'b0;
            m_exp  <= '0;
            m_frac <= '0;
            m_lzc  <= '0;
            m_zero <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                m_sign <= sign1;
                m_zero <= zero1;
                if (zero1) begin
                    m_exp  <= '0;
                    m_frac <= '0;
                    m_lzc  <= '0;
                end else begin
                    m_exp  <= exp_adj;
                    m_frac <= frac_sh;
                    m_lzc  <= lzc1;
                end
            end
        end
    end

endmodule

// File: doc/norm_shift_pipe.md
NORM_SHIFT_PIPE -- requirements
Module: norm_shift_pipe

Interface
REQ-001 SHALL have parameter C_N, default 64: fraction width; any value ≥2, power of two not required.
REQ-002 SHALL have parameter C_E, default 12: signed input exponent width; elaboration SHALL fail unless C_N ≤ 2^(C_E-1).
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 Port: clk  in  1  clock, all state on rising edge.
REQ-005 Port: rst_n  in  1  synchronous active-low reset.
REQ-006 Port: s_valid  in  1  input beat valid.
REQ-007 Port: s_ready  out  1  block accepts input this cycle.
REQ-008 Port: s_sign  in  1  sign, passed through unchanged.
REQ-009 Port: s_exp  in  C_E  signed exponent.
REQ-010 Port: s_frac  in  C_N  unnormalised fraction, MSB-first.
REQ-011 Port: m_valid  out  1  output beat valid.
REQ-012 Port: m_ready  in  1  downstream accepts output.
REQ-013 Port: m_sign  out  1  registered sign.
REQ-014 Port: m_exp  out  C_E+1  signed adjusted exponent.
REQ-015 Port: m_frac  out  C_N  normalised fraction, MSB set unless zero.
REQ-016 Port: m_lzc  out  $clog2(C_N)  leading-zero count applied.
REQ-017 Port: m_zero  out  1  input fraction was all zeros.

Function
REQ-018 Transfer SHALL occur on s_valid&s_ready (input) and m_valid&m_ready (output).
REQ-019 Two register stages: S1 registers input plus leading-zero count; S2 registers shifted fraction and adjusted exponent.
REQ-020 Latency SHALL be exactly 2 cycles from input transfer to m_valid with m_ready held high; throughput one beat per cycle.
REQ-021 Enables: en2 = ~v2 | m_ready; en1 = ~v1 | en2; s_ready = en1 (no combinational s_valid->s_ready path).
REQ-022 lzc = number of zero bits above the most significant 1 of s_frac, range 0..C_N-1.
REQ-023 Non-zero input: m_frac = s_frac << lzc (zero fill), m_exp = sign-extended s_exp - lzc, m_lzc = lzc, m_zero = 0.
REQ-024 Zero input: m_zero = 1, m_frac = 0, m_exp = 0, m_lzc = 0.
REQ-025 m_exp arithmetic SHALL be C_E+1 bits signed; no overflow possible under REQ-002.
REQ-026 While m_valid&~m_ready, all m_* outputs SHALL hold stable; no beat dropped or duplicated.
REQ-027 Simultaneous S2 drain and S1 refill in the same cycle SHALL proceed without bubble.
REQ-028 Beats SHALL leave in arrival order; m_sign SHALL track its own beat.

Reset
REQ-029 rst_n low at a rising edge SHALL clear v1, v2 and all data registers; m_valid=0, m_frac=0, m_exp=0, m_lzc=0, m_zero=0, m_sign=0.
REQ-030 s_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.
REQ-031 Reset mid-operation SHALL discard in-flight beats; none emitted after release.

Structure
REQ-032 Shared package SHALL hold the width helper for $clog2(C_N) and the exponent-width check function.
REQ-033 One sub-module norm_lzc (combinational leading-zero counter, non-power-of-two C_N by zero padding on the LSB side) SHALL feed S1.
REQ-034 Shifter SHALL be a barrel shifter in S2; no other sub-modules.

Verification (C_N=8, C_E=5 unless stated)
REQ-035 s_frac=8'b0001_0110, s_exp=3, m_ready=1 -> 2 cycles later m_frac=8'b1011_0000, m_exp=0, m_lzc=3, m_zero=0.
REQ-036 s_frac=8'h00, s_exp=-7 -> m_zero=1, m_frac=0, m_exp=0, m_lzc=0.
REQ-037 s_frac=8'h01, s_exp=-16 -> m_frac=8'h80, m_lzc=7, m_exp=-23.
REQ-038 Stream 5 beats, m_ready low cycles 3-6 -> s_ready low after both stages fill, outputs stable, all 5 beats out in order, none lost.
REQ-039 rst_n low for 1 cycle with 2 beats in flight -> m_valid=0 next cycle, s_ready=1 after release, no stale beat emitted.
REQ-040 C_N=6, C_E=4, s_frac=6'b000101, s_exp=2 -> m_frac=6'b101000, m_lzc=3, m_exp=-1.
